imm_generator: RTL and testbench

RV32I immediate generator for the core's decode stage. Takes a raw 32-bit instruction, classifies its immediate format from the opcode, and produces the sign- or zero-extended 32-bit immediate. The immediate is available combinationally for same-cycle use. A registered copy, with format and illegal flags, is also provided for the ID/EX boundary.

---
 rtl/imm_pkg.sv | 33 +++
 rtl/imm_decode.sv | 67 ++++++
 rtl/imm_generator.sv | 78 +++++++
 tb/tb_imm_generator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// imm_pkg
//   Shared definitions for the RV32I immediate generator: the immediate
//   format code carried alongside each decoded immediate, and the major
//   opcode values that select a format.
package imm_pkg;

  typedef enum logic [2:0] {
    FMT_NONE  = 3'd0,
    FMT_I     = 3'd1,
    FMT_S     = 3'd2,
    FMT_B     = 3'd3,
    FMT_U     = 3'd4,
    FMT_J     = 3'd5,
    FMT_SHAMT = 3'd6
  } imm_fmt_e;

  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  // funct3 values of OP-IMM that carry a shift amount instead of an immediate
  localparam logic [2:0] F3_SLLI      = 3'b001;
  localparam logic [2:0] F3_SRLI_SRAI = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// imm_decode
//   Purely combinational immediate decoder.
//   Ports:
//     instr   in  32  raw instruction word
//     imm     out 32  sign/zero-extended immediate (0 when the format has none)
//     fmt     out  3  immediate format code
//     illegal out  1  opcode not recognised
module imm_decode
  import imm_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm,
  output imm_fmt_e    fmt,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];

  always_comb begin
    imm     = '0;
    fmt     = FMT_NONE;
    illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_MISC_MEM, OPC_JALR, OPC_SYSTEM: begin
        imm = {{20{instr[31]}}, instr[31:20]};
        fmt = FMT_I;
      end
      OPC_OP_IMM: begin
        if ((funct3 == F3_SLLI) || (funct3 == F3_SRLI_SRAI)) begin
          // bit 30 selects SRAI and is not part of the shift amount
          imm = {27'b0, instr[24:20]};
          fmt = FMT_SHAMT;
        end else begin
          imm = {{20{instr[31]}}, instr[31:20]};
          fmt = FMT_I;
        end
      end
      OPC_STORE: begin
        imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        fmt = FMT_S;
      end
      OPC_BRANCH: begin
        imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        fmt = FMT_B;
      end
      OPC_LUI, OPC_AUIPC: begin
        imm = {instr[31:12], 12'b0};
        fmt = FMT_U;
      end
      OPC_JAL: begin
        imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        fmt = FMT_J;
      end
      OPC_OP: begin
        // register-register ops are legal but carry no immediate
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_generator.sv
// imm_generator
//   RV32I decode-stage immediate generator. The immediate and its format
//   are available combinationally; a registered copy with format, illegal
//   and valid flags is provided for the ID/EX boundary.
//   Ports:
//     clk           in   1  core clock, rising edge
//     rst_n         in   1  asynchronous active-low reset (registered outputs only)
//     instr         in  32  raw instruction word
//     instr_valid   in   1  instr is a real instruction this cycle
//     imm_out       out 32  combinational immediate
//     imm_fmt       out  3  combinational format code
//     imm_out_q     out 32  registered immediate (loads only when instr_valid)
//     imm_fmt_q     out  3  registered format code
//     imm_illegal_q out  1  registered illegal flag, meaningful while imm_valid_q
//     imm_valid_q   out  1  registered instr_valid
module imm_generator
  import imm_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic [31:0] imm_out,
  output logic [2:0]  imm_fmt,
  output logic [31:0] imm_out_q,
  output logic [2:0]  imm_fmt_q,
  output logic        imm_illegal_q,
  output logic        imm_valid_q
);

  logic [31:0] dec_imm;
  imm_fmt_e    dec_fmt;
  logic        dec_illegal;

  logic [31:0] imm_out_d;
  logic [2:0]  imm_fmt_d;
  logic        imm_illegal_d;
  logic        imm_valid_d;

  imm_decode u_imm_decode (
    .instr   (instr),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  assign imm_out = dec_imm;
  assign imm_fmt = dec_fmt;

  // Payload holds across invalid cycles so the last real instruction's
  // immediate stays visible downstream; only the valid flag tracks every cycle.
  always_comb begin
    imm_out_d     = imm_out_q;
    imm_fmt_d     = imm_fmt_q;
    imm_illegal_d = imm_illegal_q;
    imm_valid_d   = instr_valid;
    if (instr_valid) begin
      imm_out_d     = dec_imm;
      imm_fmt_d     = dec_fmt;
      imm_illegal_d = dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_out_q     <= '0;
      imm_fmt_q     <= FMT_NONE;
      imm_illegal_q <= 1'b0;
      imm_valid_q   <= 1'b0;
    end else begin
      imm_out_q     <= imm_out_d;
      imm_fmt_q     <= imm_fmt_d;
      imm_illegal_q <= imm_illegal_d;
      imm_valid_q   <= imm_valid_d;
    end
  end

endmodule

// File: tb/tb_imm_generator.sv
module tb_imm_generator;

  localparam logic [2:0] F_NONE  = 3'd0;
  localparam logic [2:0] F_I     = 3'd1;
  localparam logic [2:0] F_S     = 3'd2;
  localparam logic [2:0] F_B     = 3'd3;
  localparam logic [2:0] F_U     = 3'd4;
  localparam logic [2:0] F_J     = 3'd5;
  localparam logic [2:0] F_SHAMT = 3'd6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] imm_out;
  logic [2:0]  imm_fmt;
  logic [31:0] imm_out_q;
  logic [2:0]  imm_fmt_q;
  logic        imm_illegal_q;
  logic        imm_valid_q;

  int n_checks = 0;
  int n_fail   = 0;

  // expected registered state
  logic [31:0] exp_imm_q;
  logic [2:0]  exp_fmt_q;
  logic        exp_ill_q;
  logic        exp_vld_q;

  always #5 clk = ~clk;

  imm_generator dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .instr         (instr),
    .instr_valid   (instr_valid),
    .imm_out       (imm_out),
    .imm_fmt       (imm_fmt),
    .imm_out_q     (imm_out_q),
    .imm_fmt_q     (imm_fmt_q),
    .imm_illegal_q (imm_illegal_q),
    .imm_valid_q   (imm_valid_q)
  );

  // Reference: immediate value computed as a signed number from the field
  // weights of each format, then wrapped to 32 bits.
  function automatic void ref_decode(input logic [31:0] i, output logic [31:0] imm,
                                     output logic [2:0] fmt, output logic ill);
    longint v;
    logic [6:0] opc;
    logic [2:0] f3;
    opc = i[6:0];
    f3  = i[14:12];
    v   = 0;
    fmt = F_NONE;
    ill = 1'b0;
    if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      v   = longint'(i[24:20]);
      fmt = F_SHAMT;
    end else if (opc == 7'h03 || opc == 7'h0F || opc == 7'h67 || opc == 7'h73 || opc == 7'h13) begin
      v   = longint'(i[30:20]) - (i[31] ? 2048 : 0);
      fmt = F_I;
    end else if (opc == 7'h23) begin
      v   = longint'(i[30:25]) * 32 + longint'(i[11:7]) - (i[31] ? 2048 : 0);
      fmt = F_S;
    end else if (opc == 7'h63) begin
      v   = longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2
            - (i[31] ? 4096 : 0);
      fmt = F_B;
    end else if (opc == 7'h37 || opc == 7'h17) begin
      v   = (longint'(i[30:12]) - (i[31] ? 524288 : 0)) * 4096;
      fmt = F_U;
    end else if (opc == 7'h6F) begin
      v   = longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2
            - (i[31] ? 1048576 : 0);
      fmt = F_J;
    end else if (opc == 7'h33) begin
      v = 0;
    end else begin
      ill = 1'b1;
    end
    imm = v[31:0];
  endfunction

  task automatic apply(input logic [31:0] i, input logic v);
    @(negedge clk);
    instr       = i;
    instr_valid = v;
    #1;
  endtask

  // advance one rising edge and update the expected registered state
  task automatic clock_in();
    logic [31:0] e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    @(posedge clk);
    if (rst_n) begin
      exp_vld_q = instr_valid;
      if (instr_valid) begin
        ref_decode(instr, e_imm, e_fmt, e_ill);
        exp_imm_q = e_imm;
        exp_fmt_q = e_fmt;
        exp_ill_q = e_ill;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    instr       = 32'h00500093;
    instr_valid = 1'b1;
    exp_imm_q = '0; exp_fmt_q = F_NONE; exp_ill_q = 1'b0; exp_vld_q = 1'b0;
    #1;
    n_checks++;
    if ({imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q} !== 37'd0) begin
      n_fail++;
      $display("FAIL reset_q: got imm=%h fmt=%0d ill=%b vld=%b, want all 0",
               imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q);
    end
    @(posedge clk); #1;
    n_checks++;
    if (imm_valid_q !== 1'b0 || imm_out_q !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got imm=%h vld=%b, want 0/0", imm_out_q, imm_valid_q);
    end
    n_checks++;
    if (imm_out !== 32'h5 || imm_fmt !== F_I) begin
      n_fail++;
      $display("FAIL reset_comb: got imm=%h fmt=%0d, want 00000005/%0d", imm_out, imm_fmt, F_I);
    end
    @(negedge clk);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] t_in [15];
    logic [31:0] t_imm[15];
    logic [2:0]  t_fmt[15];
    logic        t_ill[15];
    t_in[0]  = 32'h00500093; t_imm[0]  = 32'h00000005; t_fmt[0]  = F_I;     t_ill[0]  = 0;
    t_in[1]  = 32'h00402103; t_imm[1]  = 32'h00000004; t_fmt[1]  = F_I;     t_ill[1]  = 0;
    t_in[2]  = 32'hFFF00093; t_imm[2]  = 32'hFFFFFFFF; t_fmt[2]  = F_I;     t_ill[2]  = 0;
    t_in[3]  = 32'h02312023; t_imm[3]  = 32'h00000020; t_fmt[3]  = F_S;     t_ill[3]  = 0;
    t_in[4]  = 32'h00110063; t_imm[4]  = 32'h00000000; t_fmt[4]  = F_B;     t_ill[4]  = 0;
    // instr[7]=1 supplies immediate bit 11, so this branch offset is -4
    t_in[5]  = 32'hFE000EE3; t_imm[5]  = 32'hFFFFFFFC; t_fmt[5]  = F_B;     t_ill[5]  = 0;
    t_in[6]  = 32'h00001037; t_imm[6]  = 32'h00001000; t_fmt[6]  = F_U;     t_ill[6]  = 0;
    t_in[7]  = 32'h00002017; t_imm[7]  = 32'h00002000; t_fmt[7]  = F_U;     t_ill[7]  = 0;
    t_in[8]  = 32'h0010006F; t_imm[8]  = 32'h00000800; t_fmt[8]  = F_J;     t_ill[8]  = 0;
    t_in[9]  = 32'hFFFFF06F; t_imm[9]  = 32'hFFFFFFFE; t_fmt[9]  = F_J;     t_ill[9]  = 0;
    t_in[10] = 32'h40F0D093; t_imm[10] = 32'h0000000F; t_fmt[10] = F_SHAMT; t_ill[10] = 0;
    t_in[11] = 32'h00309093; t_imm[11] = 32'h00000003; t_fmt[11] = F_SHAMT; t_ill[11] = 0;
    t_in[12] = 32'h00000033; t_imm[12] = 32'h00000000; t_fmt[12] = F_NONE;  t_ill[12] = 0;
    t_in[13] = 32'h00100073; t_imm[13] = 32'h00000001; t_fmt[13] = F_I;     t_ill[13] = 0;
    t_in[14] = 32'hFFFFFFFF; t_imm[14] = 32'h00000000; t_fmt[14] = F_NONE;  t_ill[14] = 1;
    for (int k = 0; k < 15; k++) begin
      apply(t_in[k], 1'b1);
      n_checks++;
      if (imm_out !== t_imm[k] || imm_fmt !== t_fmt[k]) begin
        n_fail++;
        $display("FAIL directed_comb[%0d] instr=%h: got imm=%h fmt=%0d, want imm=%h fmt=%0d",
                 k, t_in[k], imm_out, imm_fmt, t_imm[k], t_fmt[k]);
      end
      clock_in();
      n_checks++;
      if (imm_out_q !== t_imm[k] || imm_fmt_q !== t_fmt[k] ||
          imm_illegal_q !== t_ill[k] || imm_valid_q !== 1'b1) begin
        n_fail++;
        $display("FAIL directed_q[%0d] instr=%h: got imm=%h fmt=%0d ill=%b vld=%b, want imm=%h fmt=%0d ill=%b vld=1",
                 k, t_in[k], imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q,
                 t_imm[k], t_fmt[k], t_ill[k]);
      end
    end
  endtask

  task automatic test_hold();
    apply(32'h00500093, 1'b1);
    clock_in();
    n_checks++;
    if (imm_out_q !== 32'h5 || imm_valid_q !== 1'b1 || imm_fmt_q !== F_I) begin
      n_fail++;
      $display("FAIL hold_load: got imm=%h fmt=%0d vld=%b, want 00000005/%0d/1",
               imm_out_q, imm_fmt_q, imm_valid_q, F_I);
    end
    for (int k = 0; k < 3; k++) begin
      apply(32'hFFFFF06F ^ (32'($urandom) & 32'hFFFFF000), 1'b0);
      clock_in();
      n_checks++;
      if (imm_out_q !== 32'h5 || imm_fmt_q !== F_I || imm_valid_q !== 1'b0) begin
        n_fail++;
        $display("FAIL hold_idle[%0d]: got imm=%h fmt=%0d vld=%b, want 00000005/%0d/0",
                 k, imm_out_q, imm_fmt_q, imm_valid_q, F_I);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0]  opcs[12];
    logic [31:0] r, e_imm;
    logic [2:0]  e_fmt;
    logic        e_ill;
    opcs = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33, 7'h37, 7'h63, 7'h67, 7'h6F, 7'h73, 7'h00};
    for (int k = 0; k < 300; k++) begin
      r = $urandom;
      if ($urandom_range(0, 7) != 0) r[6:0] = opcs[$urandom_range(0, 10)];
      apply(r, 1'($urandom_range(0, 3) != 0));
      ref_decode(r, e_imm, e_fmt, e_ill);
      n_checks++;
      if (imm_out !== e_imm || imm_fmt !== e_fmt) begin
        n_fail++;
        $display("FAIL random_comb[%0d] instr=%h: got imm=%h fmt=%0d, want imm=%h fmt=%0d",
                 k, r, imm_out, imm_fmt, e_imm, e_fmt);
      end
      clock_in();
      n_checks++;
      if (imm_out_q !== exp_imm_q || imm_fmt_q !== exp_fmt_q ||
          imm_illegal_q !== exp_ill_q || imm_valid_q !== exp_vld_q) begin
        n_fail++;
        $display("FAIL random_q[%0d]: got imm=%h fmt=%0d ill=%b vld=%b, want imm=%h fmt=%0d ill=%b vld=%b",
                 k, imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q,
                 exp_imm_q, exp_fmt_q, exp_ill_q, exp_vld_q);
      end
    end
  endtask

  task automatic test_async_reset();
    apply(32'h0000007F, 1'b1);
    clock_in();
    n_checks++;
    if (imm_illegal_q !== 1'b1 || imm_valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal_q: got ill=%b vld=%b, want 1/1", imm_illegal_q, imm_valid_q);
    end
    apply(32'hFFFFF06F, 1'b1);
    clock_in();
    // assert reset mid-cycle, well before the next rising edge
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    exp_imm_q = '0; exp_fmt_q = F_NONE; exp_ill_q = 1'b0; exp_vld_q = 1'b0;
    n_checks++;
    if ({imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q} !== 37'd0) begin
      n_fail++;
      $display("FAIL async_reset: got imm=%h fmt=%0d ill=%b vld=%b, want all 0",
               imm_out_q, imm_fmt_q, imm_illegal_q, imm_valid_q);
    end
    n_checks++;
    if (imm_out !== 32'hFFFFFFFE || imm_fmt !== F_J) begin
      n_fail++;
      $display("FAIL async_reset_comb: got imm=%h fmt=%0d, want fffffffe/%0d", imm_out, imm_fmt, F_J);
    end
    // release before the edge: that edge is the first capture
    #1 rst_n = 1'b1;
    clock_in();
    n_checks++;
    if (imm_out_q !== 32'hFFFFFFFE || imm_fmt_q !== F_J || imm_valid_q !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got imm=%h fmt=%0d vld=%b, want fffffffe/%0d/1",
               imm_out_q, imm_fmt_q, imm_valid_q, F_J);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_hold();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
